// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file with fixed-priority write ports,
// combinational read ports, optional write-to-read bypass, optional
// hardwired-zero register 0 and a sequential clear engine that zeroes the
// whole array after reset or when clr is pulsed.
//
// Ports
//   clk    in   1                  clock, rising edge
//   rstn   in   1                  asynchronous active-low reset
//   wen    in   NUM_WR             per-port write enable
//   wad    in   NUM_WR*ADDR_WIDTH  packed write addresses (port i at i*ADDR_WIDTH)
//   wdata  in   NUM_WR*DATA_WIDTH  packed write data
//   rad    in   NUM_RD*ADDR_WIDTH  packed read addresses
//   rdata  out  NUM_RD*DATA_WIDTH  packed read data, combinational from rad
//   clr    in   1                  pulse: start clearing the whole array
//   busy   out  1                  high while the clear engine runs
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WR     = 2,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_WR-1:0]            wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wad,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rad,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    input  logic                         clr,
    output logic                         busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   next_cnt;
    logic                    wr_ok;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_val;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // wr_ok marks the only cycles in which user writes (and bypass) take
    // effect: READY with no clear request arriving at this edge.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        busy       = 1'b0;
        wr_ok      = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (clr) begin
                    next_cnt = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                    if (&cnt) begin
                        next_state = READY;
                    end
                end
            end
            READY: begin
                if (clr) begin
                    next_state = CLEAR;
                    next_cnt   = '0;
                end else begin
                    wr_ok = 1'b1;
                end
            end
            default: begin
                next_state = CLEAR;
                next_cnt   = '0;
            end
        endcase
    end

    // The array itself is never reset; the clear engine zeroes it one entry
    // per cycle. Ports are visited in ascending order so the highest-index
    // enabled port to a given address lands last and wins.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wen[i] &&
                    !((ZERO_REG != 0) && (wad[i*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
                    mem[wad[i*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Zero-register and busy masking are applied after the bypass so that
    // they override forwarded write data as well.
    always_comb begin
        rdata   = '0;
        rd_addr = '0;
        rd_val  = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rd_addr = rad[j*ADDR_WIDTH +: ADDR_WIDTH];
            rd_val  = mem[rd_addr];
            if ((BYPASS != 0) && wr_ok) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wen[i] && (wad[i*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr)) begin
                        rd_val = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            if (busy || ((ZERO_REG != 0) && (rd_addr == '0))) begin
                rd_val = '0;
            end
            rdata[j*DATA_WIDTH +: DATA_WIDTH] = rd_val;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Scoreboard bench for regfile_mp. Two instances share every input: dut_a
// uses ZERO_REG=1/BYPASS=1, dut_b uses ZERO_REG=0/BYPASS=0. The driver
// computes the expected response of both from an array-level model and
// queues it; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NW    = 2;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic              clr;
    logic [NW-1:0]     wen;
    logic [NW*AW-1:0]  wad;
    logic [NW*DW-1:0]  wdata;
    logic [NR*AW-1:0]  rad;
    logic [NR*DW-1:0]  rdata_a;
    logic [NR*DW-1:0]  rdata_b;
    logic              busy_a;
    logic              busy_b;

    always #5 clk = ~clk;

    regfile_mp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WR(NW), .NUM_RD(NR),
        .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rstn(rstn), .wen(wen), .wad(wad), .wdata(wdata),
        .rad(rad), .rdata(rdata_a), .clr(clr), .busy(busy_a)
    );

    regfile_mp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WR(NW), .NUM_RD(NR),
        .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rstn(rstn), .wen(wen), .wad(wad), .wdata(wdata),
        .rad(rad), .rdata(rdata_b), .clr(clr), .busy(busy_b)
    );

    typedef struct {
        logic             busy;
        logic [NR*DW-1:0] rd_a;
        logic [NR*DW-1:0] rd_b;
        int               id;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               clear_left;
    logic [DW-1:0]    mem_a [DEPTH];
    logic [DW-1:0]    mem_b [DEPTH];

    task automatic checkOutput(input string name, input int id,
                               input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, id, act, req);
        end
    endtask

    // Reference read: zero while clearing or in reset, register 0 hardwired
    // for dut_a, and dut_a forwards the highest enabled matching write port.
    function automatic logic [DW-1:0] model_read(input bit is_a, input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (clear_left > 0 || !rstn) return '0;
        if (is_a && a == 0) return '0;
        v = is_a ? mem_a[a] : mem_b[a];
        if (is_a && !clr) begin
            for (int i = 0; i < NW; i++) begin
                if (wen[i] && wad[i*AW +: AW] == a) v = wdata[i*DW +: DW];
            end
        end
        return v;
    endfunction

    // Effect of the coming rising edge. A clear (or reset) is modelled as an
    // instant wipe plus DEPTH busy cycles: nothing can observe the array
    // until the engine has finished.
    function automatic void model_edge();
        logic [AW-1:0] a;
        if (!rstn || clr) begin
            clear_left = DEPTH;
            for (int k = 0; k < DEPTH; k++) begin
                mem_a[k] = '0;
                mem_b[k] = '0;
            end
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (wen[i]) begin
                    a = wad[i*AW +: AW];
                    if (a != 0) mem_a[a] = wdata[i*DW +: DW];
                    mem_b[a] = wdata[i*DW +: DW];
                end
            end
        end
    endfunction

    task automatic applyStimulus(input bit r, input bit c, input logic [NW-1:0] we,
                                 input logic [NW*AW-1:0] wa, input logic [NW*DW-1:0] wd,
                                 input logic [NR*AW-1:0] ra);
        exp_t e;
        @(posedge clk);
        #1;
        rstn  = r;
        clr   = c;
        wen   = we;
        wad   = wa;
        wdata = wd;
        rad   = ra;
        e.busy = (clear_left > 0) || !r;
        for (int j = 0; j < NR; j++) begin
            e.rd_a[j*DW +: DW] = model_read(1'b1, ra[j*AW +: AW]);
            e.rd_b[j*DW +: DW] = model_read(1'b0, ra[j*AW +: AW]);
        end
        e.id = cyc;
        cyc++;
        sb.push_back(e);
        model_edge();
    endtask

    task automatic idle(input logic [NR*AW-1:0] ra);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, ra);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("busy_a", e.id, DW'(busy_a), DW'(e.busy));
            checkOutput("busy_b", e.id, DW'(busy_b), DW'(e.busy));
            for (int j = 0; j < NR; j++) begin
                checkOutput($sformatf("rdata_a[%0d]", j), e.id, rdata_a[j*DW +: DW], e.rd_a[j*DW +: DW]);
                checkOutput($sformatf("rdata_b[%0d]", j), e.id, rdata_b[j*DW +: DW], e.rd_b[j*DW +: DW]);
            end
        end
    end

    initial begin
        logic [AW-1:0] a0, a1, r0, r1;
        logic [DW-1:0] d0, d1;
        rstn = 1'b0;
        clr = 1'b0;
        wen = '0;
        wad = '0;
        wdata = '0;
        rad = '0;
        clear_left = DEPTH;

        // Reset, then the post-reset clear: busy for exactly DEPTH cycles.
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < DEPTH + 3; k++) idle({AW'(k % DEPTH), AW'((k + 7) % DEPTH)});
        for (int k = 0; k < DEPTH; k++) idle({AW'(DEPTH - 1 - k), AW'(k)});

        // Plain write, then read on both ports.
        applyStimulus(1'b1, 1'b0, 2'b01, {5'd0, 5'd3}, {32'd0, 32'hDEADBEEF}, {5'd3, 5'd3});
        idle({5'd3, 5'd3});

        // Same-address collision: port 1 wins.
        applyStimulus(1'b1, 1'b0, 2'b11, {5'd5, 5'd5}, {32'h22, 32'h11}, {5'd5, 5'd5});
        idle({5'd5, 5'd5});

        // Bypass in the write cycle (dut_a) versus next-cycle visibility (dut_b).
        applyStimulus(1'b1, 1'b0, 2'b01, {5'd0, 5'd7}, {32'd0, 32'hA5A5}, {5'd7, 5'd7});
        idle({5'd7, 5'd7});

        // Register 0: discarded and read as zero on dut_a, ordinary on dut_b.
        applyStimulus(1'b1, 1'b0, 2'b01, {5'd0, 5'd0}, {32'd0, 32'hFFFF}, {5'd0, 5'd0});
        idle({5'd0, 5'd0});

        // Fill with nonzero data, then clear with a dropped write and a restart.
        for (int k = 1; k < DEPTH; k++) begin
            applyStimulus(1'b1, 1'b0, 2'b01, {5'd0, AW'(k)}, {32'd0, 32'h1000_0000 + DW'(k)},
                          {AW'(k), AW'(k - 1)});
        end
        applyStimulus(1'b1, 1'b1, '0, '0, '0, {5'd9, 5'd1});
        for (int n = 1; n <= 45; n++) begin
            if (n == 4)
                applyStimulus(1'b1, 1'b0, 2'b01, {5'd0, 5'd9}, {32'd0, 32'h9999}, {5'd9, 5'd9});
            else if (n == 10)
                applyStimulus(1'b1, 1'b1, '0, '0, '0, {5'd9, 5'd2});
            else
                idle({5'd9, AW'(n % DEPTH)});
        end
        for (int k = 0; k < DEPTH; k++) idle({AW'(k), AW'(DEPTH - 1 - k)});

        // Reset in the middle of a clear and during a write.
        applyStimulus(1'b1, 1'b0, 2'b10, {5'd12, 5'd0}, {32'h1212, 32'd0}, {5'd12, 5'd12});
        applyStimulus(1'b1, 1'b1, '0, '0, '0, '0);
        for (int k = 0; k < 5; k++) idle({5'd12, 5'd3});
        applyStimulus(1'b0, 1'b0, 2'b01, {5'd0, 5'd12}, {32'd0, 32'h7777}, {5'd12, 5'd12});
        for (int k = 0; k < DEPTH + 2; k++) idle({5'd12, AW'(k % DEPTH)});

        // Randomized traffic with collisions and read-after-write biasing.
        for (int k = 0; k < 2000; k++) begin
            a0 = AW'($urandom_range(0, DEPTH - 1));
            a1 = ($urandom_range(0, 1) == 1) ? a0 : AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 1) begin
                a0 = a0 & 5'd7;
                a1 = a1 & 5'd7;
            end
            d0 = DW'($urandom);
            d1 = DW'($urandom);
            r0 = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : a0;
            r1 = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : a1;
            applyStimulus(($urandom_range(0, 255) != 0), ($urandom_range(0, 63) == 0),
                          NW'($urandom_range(0, 3)), {a1, a0}, {d1, d0}, {r1, r0});
        end
        for (int k = 0; k < DEPTH + 2; k++) idle({AW'(k % DEPTH), AW'((k * 3) % DEPTH)});

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
